// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline forwarding/hazard control slice.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_rec_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Priority compare of one source register against the two producers that will
// sit in MEM and WB next cycle; the newer (EX) producer wins.
module fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_i,
    input  logic          use_i,
    input  logic          ex_valid_i,
    input  logic          ex_regwrite_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          mem_valid_i,
    input  logic          mem_regwrite_i,
    input  logic [AW-1:0] mem_rd_i,
    output logic [1:0]    sel_o
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = use_i && ex_valid_i && ex_regwrite_i
                  && (ex_rd_i != {AW{1'b0}}) && (ex_rd_i == src_i);
        mem_hit = use_i && mem_valid_i && mem_regwrite_i
                  && (mem_rd_i != {AW{1'b0}}) && (mem_rd_i == src_i);
        if (ex_hit) begin
            sel_o = FWD_MEM;
        end else if (mem_hit) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation, load-use stall detection and flush
// handling for the 5-stage core; stage records advance every cycle.
module fwd_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic              ex_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Record rd width comes from the package; REG_AW is expected to match it.
    stage_rec_t       ex_q, ex_d;
    stage_rec_t       mem_q, mem_d;
    stage_rec_t       wb_q, wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic             ex_bubble_q, ex_bubble_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             bubble_in;
    logic             rec_unused;

    fwd_sel #(.AW(REG_AW)) u_fwd_a (
        .src_i          (id_rs1_i),
        .use_i          (id_use_rs1_i),
        .ex_valid_i     (ex_q.valid),
        .ex_regwrite_i  (ex_q.regwrite),
        .ex_rd_i        (ex_q.rd),
        .mem_valid_i    (mem_q.valid),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_rd_i       (mem_q.rd),
        .sel_o          (sel_a)
    );

    fwd_sel #(.AW(REG_AW)) u_fwd_b (
        .src_i          (id_rs2_i),
        .use_i          (id_use_rs2_i),
        .ex_valid_i     (ex_q.valid),
        .ex_regwrite_i  (ex_q.regwrite),
        .ex_rd_i        (ex_q.rd),
        .mem_valid_i    (mem_q.valid),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_rd_i       (mem_q.rd),
        .sel_o          (sel_b)
    );

    // Hazard detection and next-state for the advancing stage records.
    always_comb begin
        stall_o = id_valid_i && ex_q.valid && ex_q.memread && ex_q.regwrite
                  && (ex_q.rd != {REG_AW{1'b0}})
                  && ((id_use_rs1_i && (id_rs1_i == ex_q.rd))
                      || (id_use_rs2_i && (id_rs2_i == ex_q.rd)))
                  && !flush_i;
        bubble_in = flush_i || stall_o || !id_valid_i;

        wb_d  = mem_q;
        mem_d = ex_q;
        if (bubble_in) begin
            ex_d    = '0;
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end else begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            fwd_a_d       = sel_a;
            fwd_b_d       = sel_b;
        end
        ex_bubble_d = bubble_in;

        if (stall_o) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        // WB and the MEM load flag are tracked for completeness only.
        rec_unused = ^{wb_q, mem_q.memread};
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            ex_bubble_q <= 1'b1;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            ex_bubble_q <= ex_bubble_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign ex_bubble_o = ex_bubble_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_fwd_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_use_rs1_i;
    logic        id_use_rs2_i;
    logic [4:0]  id_rd_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic        flush_i;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic        stall_o;
    logic        ex_bubble_o;
    logic [31:0] stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o),
        .ex_bubble_o   (ex_bubble_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the falling edge, then present one ID-stage instruction.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        @(negedge clk_i);
        id_valid_i    = v;
        id_rs1_i      = rs1;
        id_use_rs1_i  = u1;
        id_rs2_i      = rs2;
        id_use_rs2_i  = u2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        id_valid_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; id_rd_i = 5'd0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;

        // Reset for two rising edges
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("rst_fwd_a", {30'd0, fwd_a_o}, 32'd0);
        chk("rst_fwd_b", {30'd0, fwd_b_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_bubble", {31'd0, ex_bubble_o}, 32'd1);
        chk("rst_cnt", stall_cnt_o, 32'd0);
        rst_i = 1'b0;

        // Back-to-back ALU: add x5; sub x8,x5; or x9,x5
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("b2b_no_stall", {31'd0, stall_o}, 32'd0);
        issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("b2b_fwd_a_mem", {30'd0, fwd_a_o}, 32'd2);
        chk("b2b_fwd_b_rf", {30'd0, fwd_b_o}, 32'd0);
        chk("b2b_bubble", {31'd0, ex_bubble_o}, 32'd0);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("b2b_fwd_a_wb", {30'd0, fwd_a_o}, 32'd1);

        // Double producer of x6, consumer on rs2
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("nop_bubble", {31'd0, ex_bubble_o}, 32'd1);
        chk("nop_fwd_a", {30'd0, fwd_a_o}, 32'd0);
        issue(1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("dbl_fwd_b_newest", {30'd0, fwd_b_o}, 32'd2);
        chk("dbl_fwd_a_rf", {30'd0, fwd_a_o}, 32'd0);

        // Load-use: lw x7; add x11,x7
        issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", {31'd0, stall_o}, 32'd1);
        chk("lu_cnt_before", stall_cnt_o, 32'd0);
        issue(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        chk("lu_stall_once", {31'd0, stall_o}, 32'd0);
        chk("lu_cnt", stall_cnt_o, 32'd1);
        chk("lu_bubble", {31'd0, ex_bubble_o}, 32'd1);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_fwd_a_wb", {30'd0, fwd_a_o}, 32'd1);
        chk("lu_after_bubble", {31'd0, ex_bubble_o}, 32'd0);

        // Load-use hazard coinciding with a flush
        issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
        chk("fl_no_stall", {31'd0, stall_o}, 32'd0);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("fl_cnt_same", stall_cnt_o, 32'd1);
        chk("fl_bubble", {31'd0, ex_bubble_o}, 32'd1);
        chk("fl_fwd_a", {30'd0, fwd_a_o}, 32'd0);

        // x0 producers never forward and never stall
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("x0_fwd_a", {30'd0, fwd_a_o}, 32'd0);
        chk("x0_fwd_b", {30'd0, fwd_b_o}, 32'd0);
        issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("x0_load_no_stall", {31'd0, stall_o}, 32'd0);

        // Reset asserted while a load-use stall is active
        issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
        chk("mid_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("mid_rst_bubble", {31'd0, ex_bubble_o}, 32'd1);
        chk("mid_rst_cnt", stall_cnt_o, 32'd0);
        chk("mid_rst_fwd_b", {30'd0, fwd_b_o}, 32'd0);
        rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
